vga_scan_module: RTL and testbench
==================================

# vga_scan_module

Raster timing generator that feeds the ROM address stage of the VGA image path. It runs horizontal and vertical counters for one VGA mode (800x600@60 at 40 MHz by default) and emits a 128x128 image-window coordinate (x, y) with a window-valid flag for the address stage. It also emits hsync, vsync and display-active flags, delayed so they stay aligned with the pixel data coming out of the address, ROM and bit-select pipeline downstream.

## Interface
- H_SYNC, 128: hsync pulse width, clocks
- H_BACK, 88: horizontal back porch
- H_VIS, 800: visible columns
- H_FRONT, 40: horizontal front porch
- V_SYNC, 4: vsync pulse width, lines
- V_BACK, 23: vertical back porch
- V_VIS, 600: visible lines
- V_FRONT, 1: vertical front porch
- X0, 336: window left edge, in visible columns; constraint X0+128 <= H_VIS
- Y0, 236: window top edge, in visible lines; constraint Y0+128 <= V_VIS
- SYNC_POL, 1: active level of hsync and vsync
- PIPE_DLY, 2: extra delay in clocks applied to vga_hs/vga_vs/vga_de; range 0..7
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- x  out  7  window column, 0..127
- y  out  7  window row, 0..127
- data_valid  out  1  (x, y) lies inside the window
- frame_start  out  1  one-clock pulse at the start of each frame
- vga_hs  out  1  hsync, delayed
- vga_vs  out  1  vsync, delayed
- vga_de  out  1  visible-area flag, delayed

## Operation
- Horizontal total H_T = H_SYNC+H_BACK+H_VIS+H_FRONT = 1056; vertical total V_T = 628.
- h_cnt runs 0..H_T-1 and wraps to 0.
- v_cnt advances only when h_cnt wraps; v_cnt runs 0..V_T-1 and wraps to 0.
- Region order in each line and each frame: sync, back porch, visible, front porch.
- Horizontal sync is active for h_cnt < H_SYNC. Visible columns are HS = H_SYNC+H_BACK (216) through HS+H_VIS-1 (1015).
- Vertical: same rule with V_SYNC. Visible lines are VS = 27 through 626.
- Window condition: h_cnt in [HS+X0, HS+X0+127] and v_cnt in [VS+Y0, VS+Y0+127].
  - With defaults: h_cnt 552..679, v_cnt 263..390.
- Inside the window: x = h_cnt-(HS+X0) and y = v_cnt-(VS+Y0), truncated to 7 bits. Outside the window, x and y hold 0.
- frame_start is high when h_cnt==0 and v_cnt==0.
- Internal hs/vs/de are produced in the same stage as data_valid. They then pass through a PIPE_DLY-deep shift register before reaching vga_hs/vga_vs/vga_de. With PIPE_DLY=0 the shift register is bypassed.
- Reset, including reset asserted mid-frame:
  - h_cnt and v_cnt clear to 0.
  - x, y, data_valid, frame_start and vga_de go to 0.
  - vga_hs and vga_vs go to ~SYNC_POL, including every stage of the delay line.
  - After reset releases, counting restarts from (0, 0) with no partial frame kept.

## Timing
- Counters update on every rising clk edge and have no stall input.
- x, y, data_valid and frame_start are registered one clock behind the counter value they decode.
- vga_hs, vga_vs and vga_de lag data_valid by exactly PIPE_DLY clocks. With the default of 2, this matches one clock for the address register plus one clock for the registered ROM.
- Line wrap (h_cnt 1055 to 0) and frame wrap (h_cnt 1055 and v_cnt 627 to 0,0) happen on the same edge. frame_start follows on the next clock.
- x steps by 1 every clock inside the window. x runs 127 then 0 with data_valid dropping on that 0. y holds its value across a whole line.

## Test plan
- Reset release, count edges: data_valid first goes high after edge 278,281 (263*1056+553), with x=0 and y=0. It stays high for 128 clocks, and x ends at 127.
- Frame period: frame_start pulses are exactly 663,168 clocks apart. vga_vs is at SYNC_POL for 4*1056 = 4,224 clocks per frame.
- Line check: vga_hs is at SYNC_POL for 128 clocks out of every 1056. vga_de is high for 800 clocks on each of 600 lines.
- Alignment: the rising edge of vga_de on window line y=0 comes PIPE_DLY=2 clocks after the internal de. Repeat with PIPE_DLY=0 and PIPE_DLY=5 and check the offset changes to match.
- Window rows: on the last window line (v_cnt 390), y=127. On the next line, data_valid stays 0 for the whole line and x and y stay 0.
- Mid-frame reset: assert rst_n=0 while data_valid=1 and x=60.
  - Immediately: x=y=0, data_valid=0, vga_hs=vga_vs=~SYNC_POL, vga_de=0.
  - After release: the first data_valid again comes after edge 278,281.

Source files
------------

// File: rtl/vga_scan_module.sv
// vga_scan_module: raster timing generator emitting a 128x128 window coordinate plus delayed hsync/vsync/de.
// Ports:
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   x_o, y_o      window column/row (0..127), 0 outside the window
//   data_valid_o  current (x_o, y_o) lies inside the window
//   frame_start_o one-clock pulse decoded from counter position (0,0)
//   vga_hs_o      hsync, PIPE_DLY clocks behind data_valid_o
//   vga_vs_o      vsync, PIPE_DLY clocks behind data_valid_o
//   vga_de_o      visible-area flag, PIPE_DLY clocks behind data_valid_o
module vga_scan_module #(
    parameter int   H_SYNC   = 128,
    parameter int   H_BACK   = 88,
    parameter int   H_VIS    = 800,
    parameter int   H_FRONT  = 40,
    parameter int   V_SYNC   = 4,
    parameter int   V_BACK   = 23,
    parameter int   V_VIS    = 600,
    parameter int   V_FRONT  = 1,
    parameter int   X0       = 336,
    parameter int   Y0       = 236,
    parameter logic SYNC_POL = 1'b1,
    parameter int   PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] x_o,
    output logic [6:0] y_o,
    output logic       data_valid_o,
    output logic       frame_start_o,
    output logic       vga_hs_o,
    output logic       vga_vs_o,
    output logic       vga_de_o
);
    localparam int H_T = H_SYNC + H_BACK + H_VIS + H_FRONT;
    localparam int V_T = V_SYNC + V_BACK + V_VIS + V_FRONT;
    localparam int HS  = H_SYNC + H_BACK;
    localparam int VS  = V_SYNC + V_BACK;
    localparam int HW  = $clog2(H_T);
    localparam int VW  = $clog2(V_T);

    // Inclusive bounds so no constant needs a bit beyond the counter width.
    localparam logic [HW-1:0] H_LAST  = HW'(H_T - 1);
    localparam logic [HW-1:0] H_SYN_E = HW'(H_SYNC);
    localparam logic [HW-1:0] H_VIS_F = HW'(HS);
    localparam logic [HW-1:0] H_VIS_L = HW'(HS + H_VIS - 1);
    localparam logic [HW-1:0] H_WIN_F = HW'(HS + X0);
    localparam logic [HW-1:0] H_WIN_L = HW'(HS + X0 + 127);
    localparam logic [VW-1:0] V_LAST  = VW'(V_T - 1);
    localparam logic [VW-1:0] V_SYN_E = VW'(V_SYNC);
    localparam logic [VW-1:0] V_VIS_F = VW'(VS);
    localparam logic [VW-1:0] V_VIS_L = VW'(VS + V_VIS - 1);
    localparam logic [VW-1:0] V_WIN_F = VW'(VS + Y0);
    localparam logic [VW-1:0] V_WIN_L = VW'(VS + Y0 + 127);

    logic [HW-1:0] h_cnt_q, h_cnt_d, h_off;
    logic [VW-1:0] v_cnt_q, v_cnt_d, v_off;
    logic          h_wrap, in_win;
    logic [6:0]    x_q, x_d, y_q, y_d;
    logic          dv_q, dv_d, fs_q, fs_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;

    always_comb begin
        h_wrap  = h_cnt_q == H_LAST;
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == V_LAST ? '0 : v_cnt_q + 1'b1);
        in_win  = h_cnt_q >= H_WIN_F && h_cnt_q <= H_WIN_L &&
                  v_cnt_q >= V_WIN_F && v_cnt_q <= V_WIN_L;
        h_off   = h_cnt_q - H_WIN_F;
        v_off   = v_cnt_q - V_WIN_F;
        x_d     = in_win ? h_off[6:0] : 7'd0;
        y_d     = in_win ? v_off[6:0] : 7'd0;
        dv_d    = in_win;
        fs_d    = h_cnt_q == '0 && v_cnt_q == '0;
        hs_d    = h_cnt_q < H_SYN_E ? SYNC_POL : ~SYNC_POL;
        vs_d    = v_cnt_q < V_SYN_E ? SYNC_POL : ~SYNC_POL;
        de_d    = h_cnt_q >= H_VIS_F && h_cnt_q <= H_VIS_L &&
                  v_cnt_q >= V_VIS_F && v_cnt_q <= V_VIS_L;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            de_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign data_valid_o  = dv_q;
    assign frame_start_o = fs_q;

    // hs/vs/de are delayed to line up with pixels leaving the downstream address/ROM pipeline.
    if (PIPE_DLY == 0) begin : g_bypass
        assign vga_hs_o = hs_q;
        assign vga_vs_o = vs_q;
        assign vga_de_o = de_q;
    end else begin : g_dly
        localparam logic [2:0] DLY_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};
        logic [2:0] dly_q [PIPE_DLY];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= DLY_RST;
            end else begin
                dly_q[0] <= {hs_q, vs_q, de_q};
                for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign {vga_hs_o, vga_vs_o, vga_de_o} = dly_q[PIPE_DLY-1];
    end
endmodule

// File: tb/tb_vga_scan_module.sv
// tb_vga_scan_module: checks vga_scan_module (shrunk raster) with vectors, corner sequences and a linear-index model.
module tb_vga_scan_module;
    localparam int HSY = 4, HBK = 3, HVI = 130, HFR = 2;
    localparam int VSY = 2, VBK = 2, VVI = 129, VFR = 1;
    localparam int WX = 1, WY = 1;
    localparam int H_T = HSY + HBK + HVI + HFR;
    localparam int V_T = VSY + VBK + VVI + VFR;
    localparam int HS = HSY + HBK, VS = VSY + VBK;
    localparam int FRAME = H_T * V_T;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n;
    int   n_chk = 0, n_fail = 0;
    logic chk_en = 1'b0;

    logic [6:0] x2, y2, x0, y0, x5, y5;
    logic dv2, fs2, hs2, vs2, de2, dv0, fs0, hs0, vs0, de0, dv5, fs5, hs5, vs5, de5;

    vga_scan_module #(.H_SYNC(HSY), .H_BACK(HBK), .H_VIS(HVI), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_VIS(VVI), .V_FRONT(VFR), .X0(WX), .Y0(WY),
        .SYNC_POL(1'b1), .PIPE_DLY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .x_o(x2), .y_o(y2), .data_valid_o(dv2), .frame_start_o(fs2),
        .vga_hs_o(hs2), .vga_vs_o(vs2), .vga_de_o(de2));
    vga_scan_module #(.H_SYNC(HSY), .H_BACK(HBK), .H_VIS(HVI), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_VIS(VVI), .V_FRONT(VFR), .X0(WX), .Y0(WY),
        .SYNC_POL(1'b0), .PIPE_DLY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .x_o(x0), .y_o(y0), .data_valid_o(dv0), .frame_start_o(fs0),
        .vga_hs_o(hs0), .vga_vs_o(vs0), .vga_de_o(de0));
    vga_scan_module #(.H_SYNC(HSY), .H_BACK(HBK), .H_VIS(HVI), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_VIS(VVI), .V_FRONT(VFR), .X0(WX), .Y0(WY),
        .SYNC_POL(1'b1), .PIPE_DLY(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .x_o(x5), .y_o(y5), .data_valid_o(dv5), .frame_start_o(fs5),
        .vga_hs_o(hs5), .vga_vs_o(vs5), .vga_de_o(de5));

    wire [18:0] o2 = {x2, y2, dv2, fs2, hs2, vs2, de2};
    wire [18:0] o0 = {x0, y0, dv0, fs0, hs0, vs0, de0};
    wire [18:0] o5 = {x5, y5, dv5, fs5, hs5, vs5, de5};

    always #5 clk = ~clk;

    // n = rising edges since reset release; after edge n the raster position is linear index n.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) n <= 0;
        else n <= n + 1;

    // Reference: decode a linear raster index k straight from the region rules (k < 0 means reset).
    function automatic logic [15:0] m_dec(int k);
        int h, v;
        logic dv;
        if (k < 0) return 16'd0;
        h = k % H_T;
        v = (k / H_T) % V_T;
        dv = h >= HS + WX && h < HS + WX + 128 && v >= VS + WY && v < VS + WY + 128;
        return {dv ? 7'(h - HS - WX) : 7'd0, dv ? 7'(v - VS - WY) : 7'd0, dv, h == 0 && v == 0};
    endfunction

    function automatic logic [2:0] m_dly(int k, logic pol);
        int h, v;
        if (k < 0) return {~pol, ~pol, 1'b0};
        h = k % H_T;
        v = (k / H_T) % V_T;
        return {h < HSY ? pol : ~pol, v < VSY ? pol : ~pol,
                h >= HS && h < HS + HVI && v >= VS && v < VS + VVI};
    endfunction

    function automatic logic [18:0] m_all(int nn, int d, logic pol);
        return {m_dec(nn - 1), m_dly(nn - 1 - d, pol)};
    endfunction

    task automatic check(string nm, logic [18:0] got, logic [18:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d got x=%0d y=%0d dv=%b fs=%b hs=%b vs=%b de=%b required x=%0d y=%0d dv=%b fs=%b hs=%b vs=%b de=%b",
                nm, n, got[18:12], got[11:5], got[4], got[3], got[2], got[1], got[0],
                exp[18:12], exp[11:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_i(string nm, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", nm, got, exp);
        end
    endtask

    // Randomly sampled comparison of all three instances against the model.
    always @(negedge clk)
        if (chk_en && rst_n && $urandom_range(0, 7) == 0) begin
            check("model_d2", o2, m_all(n, 2, 1'b1));
            check("model_d0", o0, m_all(n, 0, 1'b0));
            check("model_d5", o5, m_all(n, 5, 1'b1));
        end

    typedef struct {
        int n;
        logic [18:0] e;
    } vec_t;

    function automatic vec_t mk(int nn, int x, int y, logic dv, logic fs, logic hs, logic vs, logic de);
        vec_t t;
        t.n = nn;
        t.e = {7'(x), 7'(y), dv, fs, hs, vs, de};
        return t;
    endfunction

    task automatic reset_checks(string tag);
        check({tag, "_d2"}, o2, 19'b0);
        check({tag, "_d0"}, o0, {16'd0, 3'b110});
        check({tag, "_d5"}, o5, 19'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        int k, n0, chs, cvs, cde, cdv, cfs, chs0, r2, r0, r5;
        // Expected values for the PIPE_DLY=2, SYNC_POL=1 instance, worked out by hand.
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(6, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(280, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(281, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(703, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(704, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(705, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(706, 2, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(831, 127, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(832, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(18362, 5, 127, 1, 0, 0, 0, 1));
        tbl.push_back(mk(18501, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(18626, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(18627, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(18629, 0, 0, 0, 0, 1, 1, 0));

        repeat (3) @(negedge clk);
        reset_checks("reset_state");
        rst_n = 1'b1;
        chk_en = 1'b1;
        foreach (tbl[i]) begin
            while (n < tbl[i].n) @(negedge clk);
            check($sformatf("vec_n%0d", tbl[i].n), o2, tbl[i].e);
        end

        // One full frame from a frame_start pulse to the next.
        k = 0;
        while (!fs2 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check_i("fs_found", int'(fs2), 1);
        n0 = n;
        chs = 0; cvs = 0; cde = 0; cdv = 0; cfs = 0; chs0 = 0;
        repeat (FRAME) begin
            chs += int'(hs2);
            cvs += int'(vs2);
            cde += int'(de2);
            cdv += int'(dv2);
            cfs += int'(fs2);
            chs0 += int'(!hs0);
            @(negedge clk);
        end
        check_i("fs_period_end", int'(fs2), 1);
        check_i("fs_per_frame", cfs, 1);
        check_i("hs_active", chs, HSY * V_T);
        check_i("hs_active_pol0", chs0, HSY * V_T);
        check_i("vs_active", cvs, VSY * H_T);
        check_i("de_active", cde, HVI * VVI);
        check_i("dv_count", cdv, 128 * 128);

        // vga_de rise on window line y=0 follows internal de by PIPE_DLY.
        n0 = ((n / FRAME) + 1) * FRAME;
        while (n < n0 + 700) @(negedge clk);
        r2 = -1; r0 = -1; r5 = -1;
        repeat (12) begin
            if (de2 && r2 < 0) r2 = n;
            if (de0 && r0 < 0) r0 = n;
            if (de5 && r5 < 0) r5 = n;
            @(negedge clk);
        end
        check_i("de_rise_d2", r2 - n0, 705);
        check_i("de_rise_d0", r0 - n0, 703);
        check_i("de_rise_d5", r5 - n0, 708);

        // Reset while the window is active at x=60.
        k = 0;
        while (!(dv2 && x2 == 7'd60) && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check_i("x60_found", int'(x2), 60);
        rst_n = 1'b0;
        #1;
        reset_checks("midframe_rst");
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!dv2 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_i("first_dv_after_rst", n, 704);
        check_i("first_xy_after_rst", int'({x2, y2}), 0);

        // Random asynchronous resets; the sampled model check covers the restart.
        repeat (3) begin
            repeat ($urandom_range(50, 3000)) @(negedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            reset_checks("rand_rst");
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (1000) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
